// File: rtl/i2c_eeprom_slave.sv
// I2C target that behaves like a 24xx32-style EEPROM (2-byte address, page write,
// current/random read) backed by an internal byte array; open-drain SDA, no stretching.
module i2c_eeprom_slave #(
    parameter int         AWIDTH    = 10,
    parameter logic [6:0] SLV_ADDR  = 7'h01,
    parameter int         PAGE_BITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_SCL_i,
    input  logic              i2c_SDA_i,
    output logic              i2c_SDA_o,
    output logic              i2c_SDA_e,
    output logic              busy,
    output logic              wr_strobe,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [AWIDTH-1:0] dbg_addr,
    output logic [7:0]        dbg_rdata
);
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    localparam logic [AWIDTH-1:0] PAGE_MASK = AWIDTH'((32'd1 << PAGE_BITS) - 32'd1);

    // Write pointer advance stays inside the current page.
    function automatic logic [AWIDTH-1:0] page_inc(input logic [AWIDTH-1:0] a);
        return (a & ~PAGE_MASK) | ((a + AWIDTH'(1)) & PAGE_MASK);
    endfunction

    state_t            state, state_next;
    logic              scl_p0, scl_p1, scl_p2;
    logic              sda_p0, sda_p1, sda_p2;
    logic              scl_rise, scl_fall, sda_rise, sda_fall;
    logic              start_c, stop_c, rx_state, rx_shift;
    logic              sda_e, sda_e_next, busy_next;
    logic              set_ah, set_ptr, commit, load_rd, shift_tx;
    logic [2:0]        bit_cnt;
    logic              byte_done;
    logic [7:0]        shreg, tx_sh, ah, rd_byte;
    logic              ack_bit;
    logic [AWIDTH-1:0] pointer;
    logic [7:0]        mem [0:(1<<AWIDTH)-1];

    // p0/p1 synchronize the pins, p2 is the previous value for edge detection
    always_ff @(posedge clk) begin
        scl_p0 <= i2c_SCL_i;
        scl_p1 <= scl_p0;
        scl_p2 <= scl_p1;
        sda_p0 <= i2c_SDA_i;
        sda_p1 <= sda_p0;
        sda_p2 <= sda_p1;
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign sda_rise  = sda_p1 & ~sda_p2;
    assign sda_fall  = ~sda_p1 & sda_p2;
    assign start_c   = sda_fall & scl_p1;
    assign stop_c    = sda_rise & scl_p1;
    assign rx_state  = (state == DEV) || (state == AH) || (state == AL) || (state == WDATA);
    assign rx_shift  = rx_state & scl_rise & ~start_c & ~stop_c;
    assign rd_byte   = mem[pointer];
    assign dbg_rdata = mem[dbg_addr];
    assign i2c_SDA_o = 1'b0;
    assign i2c_SDA_e = sda_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sda_e <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            sda_e <= sda_e_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        sda_e_next = sda_e;
        busy_next  = busy;
        set_ah     = 1'b0;
        set_ptr    = 1'b0;
        commit     = 1'b0;
        load_rd    = 1'b0;
        shift_tx   = 1'b0;
        if (start_c) begin
            state_next = DEV;
            sda_e_next = 1'b0;
        end else if (stop_c) begin
            state_next = IDLE;
            sda_e_next = 1'b0;
            busy_next  = 1'b0;
        end else if (scl_fall) begin
            case (state)
                DEV: if (byte_done) begin
                    if (shreg[7:1] == SLV_ADDR) begin
                        state_next = DEV_ACK;
                        sda_e_next = 1'b1;
                        busy_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end
                DEV_ACK: if (shreg[0]) begin
                    state_next = RDATA;
                    load_rd    = 1'b1;
                    sda_e_next = ~rd_byte[7];
                end else begin
                    state_next = AH;
                    sda_e_next = 1'b0;
                end
                AH: if (byte_done) begin
                    state_next = AH_ACK;
                    sda_e_next = 1'b1;
                    set_ah     = 1'b1;
                end
                AH_ACK: begin
                    state_next = AL;
                    sda_e_next = 1'b0;
                end
                AL: if (byte_done) begin
                    state_next = AL_ACK;
                    sda_e_next = 1'b1;
                    set_ptr    = 1'b1;
                end
                AL_ACK: begin
                    state_next = WDATA;
                    sda_e_next = 1'b0;
                end
                WDATA: if (byte_done) begin
                    state_next = WDATA_ACK;
                    sda_e_next = 1'b1;
                    commit     = 1'b1;
                end
                WDATA_ACK: begin
                    state_next = WDATA;
                    sda_e_next = 1'b0;
                end
                RDATA: if (bit_cnt == 3'd7) begin
                    state_next = RDATA_ACK;
                    sda_e_next = 1'b0;
                end else begin
                    shift_tx   = 1'b1;
                    sda_e_next = ~tx_sh[6];
                end
                RDATA_ACK: if (!ack_bit) begin
                    state_next = RDATA;
                    load_rd    = 1'b1;
                    sda_e_next = ~rd_byte[7];
                end else begin
                    state_next = IDLE;
                    sda_e_next = 1'b0;
                    busy_next  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            pointer   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= pointer;
                wr_data <= shreg;
                pointer <= page_inc(pointer);
            end else if (set_ptr) begin
                pointer <= AWIDTH'({ah, shreg});
            end else if (load_rd) begin
                pointer <= pointer + AWIDTH'(1);
            end
            if (start_c || stop_c) begin
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
            end else if (load_rd) begin
                bit_cnt <= 3'd0;
            end else if (shift_tx) begin
                bit_cnt <= bit_cnt + 3'd1;
            end else if (rx_shift) begin
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end else if (scl_fall) begin
                byte_done <= 1'b0;
            end
        end
    end

    // Memory commit lands one cycle after wr_strobe.
    always_ff @(posedge clk) begin
        if (rx_shift) shreg <= {shreg[6:0], sda_p1};
        if (set_ah) ah <= shreg;
        if (load_rd) tx_sh <= rd_byte;
        else if (shift_tx) tx_sh <= {tx_sh[6:0], 1'b0};
        if (state == RDATA_ACK && scl_rise) ack_bit <= sda_p1;
        if (wr_strobe) mem[wr_addr] <= wr_data;
    end
endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Synthesizable I2C target that emulates a 24LC32A/24AA32A-style serial EEPROM with 2-byte addressing, backed by an internal byte array. It answers the same command sequences our APB EEPROM controller issues: byte/page write, current-address read, and random read via repeated START. It is used as the on-chip/loopback responder for system bring-up and as the bus model in integration benches. Pins are split open-drain style: the block only ever pulls SDA low and never stretches SCL.

## Interface
- AWIDTH, 10: memory depth is 2^AWIDTH bytes; only the low AWIDTH bits of the 16-bit received address are used, upper bits ignored.
- SLV_ADDR, 7'h01: 7-bit device address matched against the control byte.
- PAGE_BITS, 5: write page size is 2^PAGE_BITS bytes (32); must be ≤ AWIDTH.

- clk  in  1  system clock; must be ≥ 8× SCL frequency.
- rst  in  1  reset, synchronous, active-high (clock clk).
- i2c_SCL_i  in  1  SCL pin value (asynchronous).
- i2c_SDA_i  in  1  SDA pin value (asynchronous).
- i2c_SDA_o  out  1  SDA output value, constant 0.
- i2c_SDA_e  out  1  SDA output enable; 1 = pull low.
- busy  out  1  high from matched control byte until STOP/NACK/mismatch.
- wr_strobe  out  1  one-cycle pulse per byte committed to memory.
- wr_addr  out  AWIDTH  address of committed byte, valid with wr_strobe.
- wr_data  out  8  committed byte, valid with wr_strobe.
- dbg_addr  in  AWIDTH  backdoor read address.
- dbg_rdata  out  8  mem[dbg_addr], combinational.

## Operation
- SCL/SDA pass through 2-flop synchronizers, then a third register for edge detection. scl_rise/scl_fall and sda_rise/sda_fall are derived from the synchronized values.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high. Both are detected in every state and take priority over bit handling.
- Received bits are sampled on scl_rise, MSB first, into a shift register. A 3-bit counter tracks the bit position; byte complete after 8 rises.
- The block changes SDA drive only on scl_fall.
- States:
  - IDLE: SDA released; waits for START.
  - DEV: shifts in 8 bits; at the 8th bit's following scl_fall:
    - if bits[7:1]==SLV_ADDR, drives ACK; next is AH_ACK path for R/W=0, RD_LOAD path for R/W=1.
    - otherwise stays released and goes to IDLE.
  - DEV_ACK: ACK driven low for one SCL period, released on the next scl_fall.
  - AH → AH_ACK: receive address high byte, ACK.
  - AL → AL_ACK: receive address low byte, ACK. pointer ← {AH,AL}[AWIDTH-1:0]. Go to WDATA.
  - WDATA → WDATA_ACK: receive a byte. At ACK assertion, write mem[pointer], pulse wr_strobe, then increment the pointer with page wrap: the low PAGE_BITS bits wrap and the upper bits are held.
  - RDATA: at ACK-release scl_fall, load mem[pointer] and drive it (SDA_e = ~bit). Shift on each scl_fall; release after 8 bits. pointer increments with full AWIDTH wrap.
  - RDATA_ACK: sample master's ACK on scl_rise.
    - 0: next scl_fall loads the next byte (RDATA).
    - 1 (NACK): release and go to IDLE.
- Repeated START in any state → DEV with the bit counter cleared. The pointer is preserved, so a random read is: write-address phase, repeated START, read.
- STOP in any state → IDLE, SDA released, busy=0.
- Writes commit per byte immediately. There is no write-cycle time and no ACK-polling NACK.
- Memory is not reset; contents are undefined until written. pointer resets to 0.

## Timing
- Reset values: i2c_SDA_o=0, i2c_SDA_e=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, state=IDLE, pointer=0, bit counter=0.
- Internal edge detect lags the pin by 2–3 clk. SDA_e updates 1 clk after the detected scl_fall, i.e. ≤4 clk after the pin edge.
- wr_strobe is asserted in the same cycle SDA_e rises for WDATA_ACK. The memory write is visible on dbg_rdata the next cycle.
- rst mid-transfer: SDA released within 1 clk; the block ignores the bus until the next START.
- A START or STOP coinciding with a pending byte completion: START/STOP wins and no write is committed.

## Test plan
- Write 0x012 with 0xDEADBEEF (ctrl 0x02, AH 0x00, AL 0x12, 4 bytes, STOP):
  - all 7 bytes ACKed;
  - 4 wr_strobe pulses at 0x012..0x015;
  - dbg_rdata reads DE,AD,BE,EF.
- Random read: AH 0x00, AL 0x12, repeated START, ctrl 0x03, ACK ×3, NACK, STOP:
  - returns DE,AD,BE,EF;
  - SDA released after the NACK;
  - busy=0 after STOP.
- Control byte 0x04 (address 0x02):
  - no ACK (SDA_e stays 0 through the 9th clock);
  - no wr_strobe;
  - busy stays 0.
- Page wrap: write 4 bytes 11,22,33,44 at 0x01E:
  - stored at 0x01E, 0x01F, 0x000, 0x001;
  - 0x020 unchanged.
- Read wrap (AWIDTH=10): pointer 0x3FF, read 2 bytes → mem[0x3FF] then mem[0x000].
- Assert rst during the 5th bit of a data byte:
  - SDA_e=0 next cycle;
  - no write;
  - a following full write transaction completes normally.
